// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multicycle load/store core executing 16-bit instructions.
// Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> WB. Both buses are
// request/ready handshakes that hold address and data stable until ready.
module mc_cpu_core #(
  parameter int DW   = 16,
  parameter int AW   = 16,
  parameter int NREG = 16
) (
  input  logic          CK,
  input  logic          RST,
  output logic [AW-1:0] IA,
  output logic          IREQ,
  input  logic [15:0]   ID,
  input  logic          IRDY,
  output logic [AW-1:0] DA,
  output logic [DW-1:0] DWD,
  input  logic [DW-1:0] DRD,
  output logic          DWE,
  output logic          DREQ,
  input  logic          DRDY,
  output logic          HALTED
);

  localparam int RIW = $clog2(NREG);
  localparam int SW  = $clog2(DW);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t        state_reg;
  logic [15:0]   inst_reg;
  logic [AW-1:0] pc_reg;
  logic [AW-1:0] npc_reg;
  logic [AW-1:0] da_reg;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] b_reg;
  logic [DW-1:0] res_reg;
  logic [DW-1:0] dwd_reg;
  logic [7:0]    d_reg;      // low byte of R[rd], only needed by LUI
  logic          flag_reg;
  logic          cmpf_reg;   // CMP outcome, committed to flag_reg in WB
  logic          ireq_reg;
  logic          dreq_reg;
  logic          dwe_reg;
  logic          halted_reg;

  logic [DW-1:0]  rf [NREG];
  logic [3:0]     op;
  logic [RIW-1:0] rd_idx;
  logic [RIW-1:0] ra_idx;
  logic [RIW-1:0] rb_idx;
  logic [7:0]     imm8;
  logic [AW-1:0]  pc_inc;
  logic           wr_op;
  logic           wen;

  assign op     = inst_reg[15:12];
  assign rd_idx = inst_reg[8 +: RIW];
  assign ra_idx = inst_reg[4 +: RIW];
  assign rb_idx = inst_reg[0 +: RIW];
  assign imm8   = inst_reg[7:0];
  assign pc_inc = pc_reg + 1'b1;

  // ALU ops, JAL, LD, LI and LUI write rd; BF, ST, CMP and HALT do not
  assign wr_op = (op <= 4'd8) || (op == 4'hB) || (op == 4'hC) || (op == 4'hD);
  assign wen   = (state_reg == S_WB) && wr_op;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_rf
      logic [DW-1:0] r_reg;
      // One architectural register: cleared by reset, written only in WB
      always_ff @(posedge CK) begin
        if (RST) begin
          r_reg <= '0;
        end else if (wen && (rd_idx == RIW'(gi))) begin
          r_reg <= res_reg;
        end
      end
      assign rf[gi] = r_reg;
    end
  endgenerate

  // Control FSM with registered bus outputs and datapath registers
  always_ff @(posedge CK) begin
    if (RST) begin
      state_reg  <= S_FETCH;
      inst_reg   <= '0;
      pc_reg     <= '0;
      npc_reg    <= '0;
      da_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      dwd_reg    <= '0;
      d_reg      <= '0;
      flag_reg   <= 1'b0;
      cmpf_reg   <= 1'b0;
      ireq_reg   <= 1'b0;
      dreq_reg   <= 1'b0;
      dwe_reg    <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          // The request comes up one cycle after reset and stays up until accepted
          if (ireq_reg && IRDY) begin
            inst_reg  <= ID;
            ireq_reg  <= 1'b0;
            state_reg <= S_DECODE;
          end else begin
            ireq_reg <= 1'b1;
          end
        end
        S_DECODE: begin
          a_reg     <= rf[ra_idx];
          b_reg     <= rf[rb_idx];
          d_reg     <= rf[rd_idx][7:0];
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          npc_reg   <= pc_inc;
          state_reg <= S_WB;
          case (op)
            4'h0: res_reg <= a_reg + b_reg;
            4'h1: res_reg <= a_reg - b_reg;
            4'h2: res_reg <= a_reg >> b_reg[SW-1:0];
            4'h3: res_reg <= a_reg << b_reg[SW-1:0];
            4'h4: res_reg <= a_reg | b_reg;
            4'h5: res_reg <= a_reg & b_reg;
            4'h6: res_reg <= ~a_reg;
            4'h7: res_reg <= a_reg ^ b_reg;
            4'h8: begin
              res_reg <= DW'(pc_inc);
              npc_reg <= b_reg[AW-1:0];
            end
            4'h9: if (flag_reg) npc_reg <= b_reg[AW-1:0];
            4'hA, 4'hB: begin
              dreq_reg  <= 1'b1;
              da_reg    <= b_reg[AW-1:0];
              dwd_reg   <= a_reg;
              dwe_reg   <= (op == 4'hA);
              state_reg <= S_MEM;
            end
            4'hC: res_reg  <= DW'(imm8);
            4'hD: res_reg  <= DW'({imm8, d_reg});
            4'hE: cmpf_reg <= (a_reg < b_reg);
            default: begin
              halted_reg <= 1'b1;
              state_reg  <= S_HALT;
            end
          endcase
        end
        S_MEM: begin
          if (DRDY) begin
            if (!dwe_reg) res_reg <= DRD;
            dreq_reg  <= 1'b0;
            dwe_reg   <= 1'b0;
            state_reg <= S_WB;
          end
        end
        S_WB: begin
          pc_reg <= npc_reg;
          if (op == 4'hE) flag_reg <= cmpf_reg;
          ireq_reg  <= 1'b1;
          state_reg <= S_FETCH;
        end
        default: begin
          state_reg <= S_HALT;
        end
      endcase
    end
  end

  assign IA     = pc_reg;
  assign IREQ   = ireq_reg;
  assign DA     = da_reg;
  assign DWD    = dwd_reg;
  assign DWE    = dwe_reg;
  assign DREQ   = dreq_reg;
  assign HALTED = halted_reg;

endmodule

// File: tb/tb_mc_cpu_core.sv
// tb_mc_cpu_core: directed programs with bus responders and a scoreboard that
// checks every fetch address and every data-bus transaction as the core issues it.
module tb_mc_cpu_core;

  logic        CK;
  logic        RST;
  logic [15:0] IA;
  logic        IREQ;
  logic [15:0] ID;
  logic        IRDY;
  logic [15:0] DA;
  logic [15:0] DWD;
  logic [15:0] DRD;
  logic        DWE;
  logic        DREQ;
  logic        DRDY;
  logic        HALTED;

  mc_cpu_core #(.DW(16), .AW(16), .NREG(16)) dut (
    .CK(CK), .RST(RST), .IA(IA), .IREQ(IREQ), .ID(ID), .IRDY(IRDY),
    .DA(DA), .DWD(DWD), .DRD(DRD), .DWE(DWE), .DREQ(DREQ), .DRDY(DRDY),
    .HALTED(HALTED)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] data;
  } dexp_t;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] exp_f [$];
  dexp_t       exp_d [$];
  int          iwait_tab [64];
  int          dwait_tab [64];
  int          fetch_cyc [64];
  int          fetch_idx, data_idx, iw_done, dw_done, cyc;
  int          n_chk, n_fail;

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_sb();
    exp_f.delete();
    exp_d.delete();
    for (int i = 0; i < 64; i++) begin
      iwait_tab[i] = 0;
      dwait_tab[i] = 0;
      fetch_cyc[i] = 0;
    end
    fetch_idx = 0; data_idx = 0; iw_done = 0; dw_done = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'hF000;
      dmem[i] = 16'h0000;
    end
  endtask

  task automatic pf_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_f.push_back(16'(a));
  endtask

  task automatic pd(input int a, input logic we, input int d);
    dexp_t e;
    e.addr = 16'(a); e.we = we; e.data = 16'(d);
    exp_d.push_back(e);
  endtask

  // Reset for one edge, then check the reset-cycle outputs while RST is still high
  task automatic apply_reset();
    @(negedge CK); #1 RST = 1'b1;
    @(negedge CK);
    clear_sb();
    chk("rst_ireq", IREQ, 1'b0);
    chk("rst_ia", IA, 16'h0);
    chk("rst_dreq", DREQ, 1'b0);
    chk("rst_dwe", DWE, 1'b0);
    chk("rst_da", DA, 16'h0);
    chk("rst_dwd", DWD, 16'h0);
    chk("rst_halted", HALTED, 1'b0);
    #1 RST = 1'b0;
  endtask

  task automatic post_reset();
    @(negedge CK);
    chk("rst_ireq_next", IREQ, 1'b1);
    chk("rst_pc_zero", IA, 16'h0);
  endtask

  task automatic wait_halt(input string name, input int bound);
    int n;
    n = 0;
    while (!HALTED && n < bound) begin
      @(negedge CK);
      n++;
    end
    chk({name, "_halted"}, HALTED, 1'b1);
    chk({name, "_fetch_q_empty"}, exp_f.size(), 0);
    chk({name, "_data_q_empty"}, exp_d.size(), 0);
    repeat (4) begin
      @(negedge CK);
      chk({name, "_no_ireq_after_halt"}, IREQ, 1'b0);
    end
  endtask

  // Bus responders: ready is driven just after each edge, with per-transaction wait tables
  initial begin
    IRDY = 1'b0; DRDY = 1'b0; ID = '0; DRD = '0;
    forever begin
      @(posedge CK); #1;
      if (IREQ && fetch_idx < 64 && iw_done < iwait_tab[fetch_idx]) begin
        IRDY = 1'b0; iw_done++;
      end else begin
        IRDY = 1'b1;
      end
      ID = imem[IA[7:0]];
      if (DREQ && data_idx < 64 && dw_done < dwait_tab[data_idx]) begin
        DRDY = 1'b0; dw_done++;
      end else begin
        DRDY = 1'b1;
      end
      DRD = dmem[DA[7:0]];
    end
  end

  // Monitor: bus stability during waits and scoreboard pops on each handshake
  initial begin
    logic        ipend, dpend, dwe_q;
    logic [15:0] ia_q, da_q, dwd_q;
    dexp_t       e;
    ipend = 1'b0; dpend = 1'b0; dwe_q = 1'b0;
    ia_q = '0; da_q = '0; dwd_q = '0;
    cyc = 0;
    forever begin
      @(negedge CK);
      cyc++;
      if (RST) begin
        ipend = 1'b0;
        dpend = 1'b0;
      end else begin
        if (ipend) begin
          chk("ireq_held", IREQ, 1'b1);
          chk("ia_held", IA, ia_q);
        end
        if (dpend) begin
          chk("dreq_held", DREQ, 1'b1);
          chk("da_held", DA, da_q);
          chk("dwe_held", DWE, dwe_q);
          chk("dwd_held", DWD, dwd_q);
        end
        ipend = IREQ && !IRDY; ia_q = IA;
        dpend = DREQ && !DRDY; da_q = DA; dwe_q = DWE; dwd_q = DWD;
        if (IREQ && IRDY) begin
          $display("fetch  IA=%h ID=%h cycle=%0d", IA, ID, cyc);
          if (exp_f.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL fetch_unexpected: got IA=%h, expected no fetch", IA);
          end else begin
            chk("fetch_addr", IA, exp_f.pop_front());
          end
          if (fetch_idx < 64) fetch_cyc[fetch_idx] = cyc;
          fetch_idx++; iw_done = 0;
        end
        if (DREQ && DRDY) begin
          $display("data   DA=%h WE=%b WD=%h RD=%h", DA, DWE, DWD, DRD);
          if (exp_d.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL data_unexpected: got DA=%h, expected no access", DA);
          end else begin
            e = exp_d.pop_front();
            chk("data_addr", DA, e.addr);
            chk("data_we", DWE, e.we);
            if (e.we) chk("store_data", DWD, e.data);
          end
          if (DWE) dmem[DA[7:0]] = DWD;
          data_idx++; dw_done = 0;
        end
      end
    end
  end

  task automatic load_t2();
    clear_mem();
    imem[0] = 16'hC134; imem[1] = 16'hD112; imem[2] = 16'hC240; imem[3] = 16'hA012;
    imem[4] = 16'hB502; imem[5] = 16'hC641; imem[6] = 16'hA056; imem[7] = 16'hF000;
  endtask

  task automatic push_t2();
    pf_range(0, 7);
    pd(16'h40, 1'b1, 16'h1234);
    pd(16'h40, 1'b0, 0);
    pd(16'h41, 1'b1, 16'h1234);
  endtask

  initial begin
    int n;
    RST = 1'b1;
    n_chk = 0; n_fail = 0;
    clear_sb();
    clear_mem();

    // T1: LI/LI/ADD/SUB, results exposed by stores; four instructions in 16 cycles
    imem[0] = 16'hC105; imem[1] = 16'hC203; imem[2] = 16'h0312; imem[3] = 16'h1412;
    imem[4] = 16'hC980; imem[5] = 16'hA039; imem[6] = 16'hC981; imem[7] = 16'hA049;
    imem[8] = 16'hF000;
    apply_reset();
    pf_range(0, 8);
    pd(16'h80, 1'b1, 8);
    pd(16'h81, 1'b1, 2);
    post_reset();
    wait_halt("t1", 300);
    chk("t1_latency", fetch_cyc[4] - fetch_cyc[0], 16);

    // T2: LI + LUI build 0x1234, store then load it back and re-store it
    load_t2();
    apply_reset();
    push_t2();
    post_reset();
    wait_halt("t2", 300);
    chk("t2_latency", fetch_cyc[7] - fetch_cyc[0], 31);

    // T3: CMP sets FLAG and BF is taken; CMP clears FLAG and BF falls through
    clear_mem();
    imem[0] = 16'hC102; imem[1] = 16'hC207; imem[2] = 16'hC620; imem[3] = 16'hE012;
    imem[4] = 16'h9006; imem[16'h20] = 16'hE021; imem[16'h21] = 16'h9006;
    imem[16'h22] = 16'hF000;
    apply_reset();
    pf_range(0, 4);
    pf_range(16'h20, 16'h22);
    post_reset();
    wait_halt("t3", 300);

    // T4: JAL link/target, JAL with rd==rb, SHL by 15, SUB underflow, SHR, XOR
    clear_mem();
    imem[0] = 16'hC810; imem[1] = 16'hC101; imem[2] = 16'hC20F; imem[3] = 16'hC300;
    imem[4] = 16'hC990; imem[5] = 16'h8708;
    imem[16'h10] = 16'hA079; imem[16'h11] = 16'h3412; imem[16'h12] = 16'hC991;
    imem[16'h13] = 16'hA049; imem[16'h14] = 16'h1531; imem[16'h15] = 16'hC992;
    imem[16'h16] = 16'hA059; imem[16'h17] = 16'hCA30; imem[16'h18] = 16'h8AAA;
    imem[16'h30] = 16'hC993; imem[16'h31] = 16'hA0A9; imem[16'h32] = 16'h2B42;
    imem[16'h33] = 16'hC994; imem[16'h34] = 16'hA0B9; imem[16'h35] = 16'h7C54;
    imem[16'h36] = 16'hC995; imem[16'h37] = 16'hA0C9; imem[16'h38] = 16'hF000;
    apply_reset();
    pf_range(0, 5);
    pf_range(16'h10, 16'h18);
    pf_range(16'h30, 16'h38);
    pd(16'h90, 1'b1, 16'h0006);
    pd(16'h91, 1'b1, 16'h8000);
    pd(16'h92, 1'b1, 16'hFFFF);
    pd(16'h93, 1'b1, 16'h0019);
    pd(16'h94, 1'b1, 16'h0001);
    pd(16'h95, 1'b1, 16'h7FFF);
    post_reset();
    wait_halt("t4", 400);

    // T5: T2 again with 3 fetch wait cycles and 2 data wait cycles
    load_t2();
    apply_reset();
    push_t2();
    iwait_tab[2] = 3;
    dwait_tab[0] = 2;
    post_reset();
    wait_halt("t5", 300);
    chk("t5_latency", fetch_cyc[7] - fetch_cyc[0], 36);

    // T6: reset while a store waits; then registers must read back as zero
    clear_mem();
    imem[0] = 16'hA032; imem[1] = 16'hC355; imem[2] = 16'hA032; imem[3] = 16'hF000;
    apply_reset();
    pf_range(0, 2);
    pd(0, 1'b1, 0);
    dwait_tab[1] = 20;
    post_reset();
    n = 0;
    while (!(fetch_idx == 3 && DREQ) && n < 100) begin
      @(negedge CK);
      n++;
    end
    chk("t6_reached_mem_wait", DREQ, 1'b1);
    @(negedge CK);
    @(negedge CK);
    chk("t6_pre_fetch_q_empty", exp_f.size(), 0);
    chk("t6_pre_data_q_empty", exp_d.size(), 0);
    apply_reset();
    pf_range(0, 3);
    pd(0, 1'b1, 16'h0000);
    pd(0, 1'b1, 16'h0055);
    post_reset();
    wait_halt("t6", 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
